car_state_uart_tx: RTL and testbench
====================================

Name: car_state_uart_tx

Overview:
- Serialises one car's collision-box centres, heading and flag into a fixed 8-byte frame and transmits it over UART 8N1.
- The peer board's receiver reconstructs `other_f_x`, `other_f_y`, `other_r_x` and `other_r_y` for its physics engine.
- Sits beside the physics engine. It is driven by the engine's `my_*`, `angle_idx` and `flag` outputs plus a per-game-tick request pulse.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- BAUD, 115200, UART bit rate; clocks-per-bit BIT_DIV = CLK_FREQ/BAUD (integer division, minimum 2).
- SYNC_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- frame_req  in  1  single-cycle request to send a snapshot (game tick)
- send_en  in  1  transmission allowed (high only while racing state active)
- my_f_x  in  10  front box centre x
- my_f_y  in  10  front box centre y
- my_r_x  in  10  rear box centre x
- my_r_y  in  10  rear box centre y
- angle_idx  in  4  heading index 0..15
- flag  in  2  car status flag
- tx  out  1  UART serial line, idle high
- busy  out  1  frame in progress
- frame_sent  out  1  one-cycle pulse after the stop bit of byte 7 completes
- seq  out  2  sequence number of the next frame

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: tx=1, busy=0, frame_sent=0, seq=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts the frame: tx returns to 1 at the reset edge and no partial byte continues.
- Accept rule: in IDLE, when frame_req && send_en, the snapshot is latched on that edge.
  - Latched fields: all coordinates, angle_idx, flag and current seq.
  - busy=1 from the next cycle.
- Requests while busy, or with send_en=0, are ignored. There is no queue and no counting.
- Byte order, each byte sent LSB first:
  - B0 = SYNC_BYTE
  - B1 = f_x[9:2]
  - B2 = {f_x[1:0], f_y[9:4]}
  - B3 = {f_y[3:0], r_x[9:6]}
  - B4 = {r_x[5:0], r_y[9:8]}
  - B5 = r_y[7:0]
  - B6 = {angle_idx, flag, seq}
  - B7 = B1^B2^B3^B4^B5^B6 (B0 is excluded from the checksum)
- FSM: IDLE -> LOAD -> SEND -> WAIT_BYTE -> (next byte: SEND | after B7: DONE) -> IDLE.
  - LOAD: compute B1..B7 from the snapshot into a byte buffer (one cycle).
  - SEND: issue byte index 0..7 to the byte serialiser.
  - WAIT_BYTE: hold until the serialiser reports done.
  - DONE: pulse frame_sent, seq <= seq+1 (wraps 3->0), busy=0 on the following cycle.
- Serialiser: start bit 0, 8 data bits, stop bit 1. Each bit lasts exactly BIT_DIV clocks. Bytes are sent back-to-back with no idle gap beyond the stop bit.
- Timing:
  - Start bit of B0 begins on the 2nd cycle after the accept edge.
  - Frame length is 80*BIT_DIV clocks of tx activity.
- Snapshot inputs may change freely during a frame. The transmitted data reflects only the latched values.
- Deasserting send_en mid-frame does not abort the frame; it only blocks new accepts.
- Requirement: BIT_DIV*80 < CLK_FREQ/60, so that every game tick can be served.

Decomposition:
- Shared package holds:
  - SYNC_BYTE default
  - FRAME_BYTES=8
  - CSUM_IDX=7
  - FSM state encodings
  - the byte-packing function (reused by the receiver's unpacker, so both ends share the bit layout).
- One natural sub-module, uart_byte_tx:
  - Interface: start/data[7:0] in, tx/busy/done out.
  - Owns the baud counter and the bit index.
  - The frame FSM stays in car_state_uart_tx.

Test Plan (bench overrides CLK_FREQ=1000, BAUD=100 -> BIT_DIV=10):
- Basic frame:
  - Stimulus: f_x=160, f_y=120, r_x=158, r_y=120, angle_idx=4, flag=0, seq=0; pulse frame_req with send_en=1.
  - Expected: the decoded bytes are A5 28 07 82 78 78 40 ED; frame_sent fires exactly 800 cycles after the B0 start bit begins; seq becomes 1.
- Ignored requests:
  - Stimulus: pulse frame_req at cycle 300 of an active frame, and separately pulse it with send_en=0.
  - Expected: no second frame; tx stays high after frame_sent; seq increments only once.
- Sequence wrap: send 5 frames -> the low two bits of B6 are 0,1,2,3,0; every B7 matches the XOR of B1..B6.
- Mid-frame reset: assert rst during bit 3 of B2 -> tx=1, busy=0 and seq=0 on the next cycle; a subsequent request sends a complete, correct frame starting with A5.
- Snapshot stability: change all coordinate inputs to 10'h3FF during B3 -> the transmitted frame still carries the latched values and checksum 0xED.
- Bit timing: measure each tx level segment -> every start, data and stop bit is exactly 10 cycles, and there is no gap between a stop bit and the next start bit.

Source files
------------

// File: rtl/car_state_uart_tx_pkg.sv
// Shared frame layout for the car-state UART link: constants, FSM encoding and
// the byte-packing function used by both the transmitter and the peer's unpacker.
package car_state_uart_tx_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES       = 8;
    localparam logic [2:0] CSUM_IDX          = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_BYTE,
        ST_DONE
    } state_t;

    typedef logic [FRAME_BYTES-1:0][7:0] frame_t;

    // The checksum covers B1..B6 only; the sync byte stays out of it.
    function automatic frame_t pack_frame(
        input logic [7:0] sync,
        input logic [9:0] f_x,
        input logic [9:0] f_y,
        input logic [9:0] r_x,
        input logic [9:0] r_y,
        input logic [3:0] angle_idx,
        input logic [1:0] flag,
        input logic [1:0] seq
    );
        frame_t f;
        f[0] = sync;
        f[1] = f_x[9:2];
        f[2] = {f_x[1:0], f_y[9:4]};
        f[3] = {f_y[3:0], r_x[9:6]};
        f[4] = {r_x[5:0], r_y[9:8]};
        f[5] = r_y[7:0];
        f[6] = {angle_idx, flag, seq};
        f[7] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
        return f;
    endfunction

endpackage

// File: rtl/car_state_uart_tx_uart_byte_tx.sv
// 8N1 byte serialiser. A new start is taken during the last stop-bit clock so
// consecutive bytes leave the line with no idle gap.
module uart_byte_tx #(
    parameter int BIT_DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);
    localparam int             CW       = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0]  CNT_PRE  = CW'(BIT_DIV - 2);

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_tx;
    logic          r_busy;
    logic          w_last;

    assign w_last = r_busy && (r_bit == 4'd9) && (r_cnt == CNT_LAST);
    // done leads the end of the stop bit by one clock so the caller can
    // present the next byte exactly on the bit boundary.
    assign o_done = r_busy && (r_bit == 4'd9) && (r_cnt == CNT_PRE);
    assign o_tx   = r_tx;
    assign o_busy = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (i_start && (!r_busy || w_last)) begin
            r_shift <= {1'b1, i_data};
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else if (r_busy) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_busy <= 1'b0;
                    r_tx   <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b0, r_shift[8:1]};
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/car_state_uart_tx.sv
// Frame sequencer: latches one car snapshot per accepted tick request and
// streams it as an 8-byte sync/payload/checksum frame over UART.
module car_state_uart_tx
    import car_state_uart_tx_pkg::*;
#(
    parameter int         CLK_FREQ  = 100_000_000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_req,
    input  logic       send_en,
    input  logic [9:0] my_f_x,
    input  logic [9:0] my_f_y,
    input  logic [9:0] my_r_x,
    input  logic [9:0] my_r_y,
    input  logic [3:0] angle_idx,
    input  logic [1:0] flag,
    output logic       tx,
    output logic       busy,
    output logic       frame_sent,
    output logic [1:0] seq
);
    localparam int BIT_DIV_RAW = CLK_FREQ / BAUD;
    localparam int BIT_DIV     = (BIT_DIV_RAW < 2) ? 2 : BIT_DIV_RAW;

    state_t     r_state;
    frame_t     r_buf;
    logic [9:0] r_f_x, r_f_y, r_r_x, r_r_y;
    logic [3:0] r_angle;
    logic [1:0] r_flag, r_snap_seq, r_seq;
    logic [2:0] r_idx;
    logic       r_busy, r_frame_sent;
    logic       w_start, w_done, w_ser_busy;
    logic [7:0] w_byte;

    assign w_start    = (r_state == ST_SEND);
    assign w_byte     = r_buf[r_idx];
    assign busy       = r_busy;
    assign frame_sent = r_frame_sent;
    assign seq        = r_seq;

    uart_byte_tx #(.BIT_DIV(BIT_DIV)) u_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_data  (w_byte),
        .o_tx    (tx),
        .o_busy  (w_ser_busy),
        .o_done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_f_x        <= '0;
            r_f_y        <= '0;
            r_r_x        <= '0;
            r_r_y        <= '0;
            r_angle      <= '0;
            r_flag       <= '0;
            r_snap_seq   <= '0;
            r_seq        <= '0;
            r_idx        <= '0;
            r_busy       <= 1'b0;
            r_frame_sent <= 1'b0;
        end else begin
            r_frame_sent <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_req && send_en && !w_ser_busy) begin
                        r_f_x      <= my_f_x;
                        r_f_y      <= my_f_y;
                        r_r_x      <= my_r_x;
                        r_r_y      <= my_r_y;
                        r_angle    <= angle_idx;
                        r_flag     <= flag;
                        r_snap_seq <= r_seq;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_buf   <= pack_frame(SYNC_BYTE, r_f_x, r_f_y, r_r_x, r_r_y,
                                          r_angle, r_flag, r_snap_seq);
                    r_idx   <= '0;
                    r_state <= ST_SEND;
                end
                ST_SEND: r_state <= ST_WAIT_BYTE;
                ST_WAIT_BYTE: begin
                    if (w_done) begin
                        if (r_idx == CSUM_IDX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_DONE: begin
                    r_frame_sent <= 1'b1;
                    r_seq        <= r_seq + 2'd1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_car_state_uart_tx.sv
// Bench for car_state_uart_tx at BIT_DIV=10: a line decoder feeds a byte
// scoreboard while per-scenario tasks check timing, seq and control outputs.
module tb_car_state_uart_tx;
    localparam int BIT_DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_req = 1'b0;
    logic       send_en = 1'b0;
    logic [9:0] my_f_x = '0, my_f_y = '0, my_r_x = '0, my_r_y = '0;
    logic [3:0] angle_idx = '0;
    logic [1:0] flag = '0;
    logic       tx, busy, frame_sent;
    logic [1:0] seq;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic [1:0] model_seq = 2'd0;

    car_state_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_req  (frame_req),
        .send_en    (send_en),
        .my_f_x     (my_f_x),
        .my_f_y     (my_f_y),
        .my_r_x     (my_r_x),
        .my_r_y     (my_r_y),
        .angle_idx  (angle_idx),
        .flag       (flag),
        .tx         (tx),
        .busy       (busy),
        .frame_sent (frame_sent),
        .seq        (seq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Line decoder: samples mid-bit on the falling edge, checks edge alignment
    // and inter-byte spacing, and compares each byte against the scoreboard.
    logic       mon_active = 1'b0;
    logic       mon_prev = 1'b1;
    int         mon_cnt = 0;
    int         mon_pos = 0;
    int         mon_last_start = 0;
    logic [7:0] mon_byte = '0;
    logic [7:0] rx_frame[8];

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_pos    = 0;
        end else if (!mon_active && tx === 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            if (mon_pos > 0) begin
                vectors++;
                if (cyc - mon_last_start !== 10 * BIT_DIV) begin
                    miscompares++;
                    $display("FAIL byte_spacing: got %0d cycles expected %0d", cyc - mon_last_start, 10 * BIT_DIV);
                end
            end
            mon_last_start = cyc;
        end else if (mon_active) begin
            mon_cnt++;
            if (tx !== mon_prev) begin
                vectors++;
                if (mon_cnt % BIT_DIV != 0) begin
                    miscompares++;
                    $display("FAIL bit_edge: edge at offset %0d expected a multiple of %0d", mon_cnt, BIT_DIV);
                end
            end
            if (mon_cnt % BIT_DIV == BIT_DIV / 2) begin
                if (mon_cnt / BIT_DIV >= 1 && mon_cnt / BIT_DIV <= 8)
                    mon_byte[mon_cnt / BIT_DIV - 1] = tx;
                if (mon_cnt / BIT_DIV == 9) begin
                    vectors++;
                    if (tx !== 1'b1) begin
                        miscompares++;
                        $display("FAIL stop_bit: got %b expected 1", tx);
                    end
                    rx_frame[mon_pos] = mon_byte;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL byte_data: got %02h expected no byte", mon_byte);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (mon_byte !== e) begin
                            miscompares++;
                            $display("FAIL byte_data[%0d]: got %02h expected %02h", mon_pos, mon_byte, e);
                        end
                    end
                    mon_pos    = (mon_pos + 1) % 8;
                    mon_active = 1'b0;
                end
            end
        end
        mon_prev = tx;
    end

    task automatic push_frame(input logic [9:0] fx, input logic [9:0] fy, input logic [9:0] rx,
                              input logic [9:0] ry, input logic [3:0] ang, input logic [1:0] flg,
                              input logic [1:0] sq, input int nbytes);
        logic [7:0] b[8];
        b[0] = 8'hA5;
        b[1] = fx[9:2];
        b[2] = {fx[1:0], fy[9:4]};
        b[3] = {fy[3:0], rx[9:6]};
        b[4] = {rx[5:0], ry[9:8]};
        b[5] = ry[7:0];
        b[6] = {ang, flg, sq};
        b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
    endtask

    task automatic drive_request(input logic [9:0] fx, input logic [9:0] fy, input logic [9:0] rx,
                                 input logic [9:0] ry, input logic [3:0] ang, input logic [1:0] flg);
        @(posedge clk); #1;
        my_f_x = fx; my_f_y = fy; my_r_x = rx; my_r_y = ry;
        angle_idx = ang; flag = flg;
        frame_req = 1'b1; send_en = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
    endtask

    task automatic send_frame(input logic [9:0] fx, input logic [9:0] fy, input logic [9:0] rx,
                              input logic [9:0] ry, input logic [3:0] ang, input logic [1:0] flg,
                              input int req_at, input int corrupt_at);
        int n;
        logic [1:0] exp_seq;
        logic [7:0] x;
        push_frame(fx, fy, rx, ry, ang, flg, model_seq, 8);
        drive_request(fx, fy, rx, ry, ang, flg);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL tx_before_start: got %b expected 1", tx); end
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b0) begin miscompares++; $display("FAIL start_latency: tx got %b expected 0", tx); end
        n = 0;
        while (n < 2000 && frame_sent !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (n == req_at) frame_req = 1'b1;
            if (n == req_at + 1) frame_req = 1'b0;
            if (n == corrupt_at) begin
                my_f_x = 10'h3FF; my_f_y = 10'h3FF; my_r_x = 10'h3FF; my_r_y = 10'h3FF;
            end
        end
        vectors++;
        if (n !== 80 * BIT_DIV) begin miscompares++; $display("FAIL frame_length: got %0d cycles expected %0d", n, 80 * BIT_DIV); end
        exp_seq = model_seq + 2'd1;
        vectors++;
        if (seq !== exp_seq) begin miscompares++; $display("FAIL seq_incr: got %0d expected %0d", seq, exp_seq); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_after_done: got %b expected 0", busy); end
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL bytes_left: got %0d expected 0", exp_q.size()); end
        vectors++;
        if (rx_frame[6][1:0] !== model_seq) begin miscompares++; $display("FAIL rx_seq: got %0d expected %0d", rx_frame[6][1:0], model_seq); end
        x = rx_frame[1] ^ rx_frame[2] ^ rx_frame[3] ^ rx_frame[4] ^ rx_frame[5] ^ rx_frame[6];
        vectors++;
        if (rx_frame[7] !== x) begin miscompares++; $display("FAIL rx_checksum: got %02h expected %02h", rx_frame[7], x); end
        @(posedge clk); #1;
        vectors++;
        if (frame_sent !== 1'b0) begin miscompares++; $display("FAIL frame_sent_pulse: got %b expected 0", frame_sent); end
        model_seq = exp_seq;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        frame_req = 1'b0;
        send_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        model_seq = 2'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (frame_sent !== 1'b0) begin miscompares++; $display("FAIL reset_frame_sent: got %b expected 0", frame_sent); end
        vectors++;
        if (seq !== 2'd0) begin miscompares++; $display("FAIL reset_seq: got %0d expected 0", seq); end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        // Also pulses frame_req 300 cycles into the frame; it must be ignored.
        send_frame(10'd160, 10'd120, 10'd158, 10'd120, 4'd4, 2'd0, 300, -1);
    endtask

    task automatic test_ignored_requests();
        int low_seen = 0, busy_seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) low_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        @(posedge clk); #1;
        send_en = 1'b0; frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (tx !== 1'b1) low_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        vectors++;
        if (low_seen !== 0) begin miscompares++; $display("FAIL ignored_tx_idle: got %0d low cycles expected 0", low_seen); end
        vectors++;
        if (busy_seen !== 0) begin miscompares++; $display("FAIL ignored_busy: got %0d busy cycles expected 0", busy_seen); end
        vectors++;
        if (seq !== model_seq) begin miscompares++; $display("FAIL ignored_seq: got %0d expected %0d", seq, model_seq); end
    endtask

    task automatic test_mid_reset();
        int n;
        push_frame(10'd160, 10'd120, 10'd158, 10'd120, 4'd4, 2'd0, model_seq, 2);
        drive_request(10'd160, 10'd120, 10'd158, 10'd120, 4'd4, 2'd0);
        n = 0;
        while (n < 20 && tx !== 1'b0) begin @(posedge clk); #1; n++; end
        repeat (245) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL midreset_tx: got %b expected 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        vectors++;
        if (seq !== 2'd0) begin miscompares++; $display("FAIL midreset_seq: got %0d expected 0", seq); end
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL midreset_bytes: got %0d pending expected 0", exp_q.size()); end
        rst = 1'b0;
        model_seq = 2'd0;
        exp_q.delete();
    endtask

    task automatic test_snapshot_stability();
        send_frame(10'd160, 10'd120, 10'd158, 10'd120, 4'd4, 2'd0, -10, 350);
        vectors++;
        if (rx_frame[7] !== 8'hED) begin miscompares++; $display("FAIL snapshot_csum: got %02h expected ED", rx_frame[7]); end
        vectors++;
        if (rx_frame[1] !== 8'h28) begin miscompares++; $display("FAIL snapshot_b1: got %02h expected 28", rx_frame[1]); end
    endtask

    task automatic test_seq_wrap();
        apply_reset();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_frame(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                       10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                       4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), -10, -10);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_ignored_requests();
        test_mid_reset();
        test_snapshot_stability();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
